// File: rtl/lvds_seq_pkg.sv
// Shared types and helpers for the LVDS panel power sequencer: state encoding,
// timer width, ms->cycle conversion and the sequencing transition rules.
package lvds_seq_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_VDD_ON     = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_DATA_ON    = 3'd3,
        ST_ON         = 3'd4,
        ST_BL_OFF     = 3'd5,
        ST_DATA_OFF   = 3'd6,
        ST_OFF_HOLD   = 3'd7
    } seq_state_e;

    function automatic logic [TIMER_W-1:0] ms2cyc(input int unsigned ms, input int unsigned khz);
        return TIMER_W'(ms * khz);
    endfunction

    // Power-down states ignore req so a started shutdown always runs to OFF.
    function automatic seq_state_e next_state(input seq_state_e st, input logic req,
                                              input logic fs, input logic tz);
        seq_state_e nx;
        nx = st;
        case (st)
            ST_OFF:        if (req) nx = ST_VDD_ON;
            ST_VDD_ON:     if (!req) nx = ST_DATA_OFF; else if (tz) nx = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (!req) nx = ST_DATA_OFF; else if (fs) nx = ST_DATA_ON;
            ST_DATA_ON:    if (!req) nx = ST_DATA_OFF; else if (tz) nx = ST_ON;
            ST_ON:         if (!req) nx = ST_BL_OFF;
            ST_BL_OFF:     if (tz) nx = ST_DATA_OFF;
            ST_DATA_OFF:   if (tz) nx = ST_OFF_HOLD;
            ST_OFF_HOLD:   if (tz) nx = ST_OFF;
            default:       nx = ST_OFF;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/lvds_seq_timer.sv
// Loadable down-counter that saturates at zero; a state dwells load_val+1 cycles
// before zero is seen.
module lvds_seq_timer
    import lvds_seq_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lvds_panel_sequencer.sv
// Power sequencer for a dual-channel LVDS panel: orders VDD, LVDS and backlight.
// Optional backlight PWM dimming is built when BL_PWM_EN is defined.
module lvds_panel_sequencer
    import lvds_seq_pkg::*;
#(
    parameter int unsigned CLK_KHZ    = 180000,
    parameter int unsigned T_VDD_DATA = 20,
    parameter int unsigned T_DATA_BL  = 200,
    parameter int unsigned T_BL_DATA  = 200,
    parameter int unsigned T_DATA_VDD = 20,
    parameter int unsigned T_OFF_MIN  = 1000,
    parameter int unsigned PWM_DIV    = 70
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       panel_on_req,
    input  logic       frame_start,
    input  logic [7:0] bl_duty,
    output logic       panel_vdd_en,
    output logic       lvds_en,
    output logic       bl_en,
    output logic       bl_pwm,
    output logic       panel_ready,
    output logic [2:0] state
);

    seq_state_e         state_q, state_nx;
    logic               tmr_load, tmr_zero;
    logic [TIMER_W-1:0] tmr_val, unused_tmr_value;
    logic               vdd_q, lvds_q, bl_q, ready_q;

    // Timer reload happens on the same edge the state changes into a timed state.
    always_comb begin
        state_nx = next_state(state_q, panel_on_req, frame_start, tmr_zero);
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_nx != state_q) begin
            tmr_load = 1'b1;
            case (state_nx)
                ST_VDD_ON:   tmr_val = ms2cyc(T_VDD_DATA, CLK_KHZ) - 1;
                ST_DATA_ON:  tmr_val = ms2cyc(T_DATA_BL,  CLK_KHZ) - 1;
                ST_BL_OFF:   tmr_val = ms2cyc(T_BL_DATA,  CLK_KHZ) - 1;
                ST_DATA_OFF: tmr_val = ms2cyc(T_DATA_VDD, CLK_KHZ) - 1;
                ST_OFF_HOLD: tmr_val = ms2cyc(T_OFF_MIN,  CLK_KHZ) - 1;
                default:     tmr_load = 1'b0;
            endcase
        end
    end

    lvds_seq_timer #(.W(TIMER_W)) u_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (unused_tmr_value),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            vdd_q   <= 1'b0;
            lvds_q  <= 1'b0;
            bl_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            vdd_q   <= (state_nx != ST_OFF) && (state_nx != ST_OFF_HOLD);
            lvds_q  <= state_nx inside {ST_DATA_ON, ST_ON, ST_BL_OFF};
            bl_q    <= (state_nx == ST_ON);
            ready_q <= (state_nx == ST_ON);
        end
    end

    assign panel_vdd_en = vdd_q;
    assign lvds_en      = lvds_q;
    assign bl_en        = bl_q;
    assign panel_ready  = ready_q;
    assign state        = state_q;

`ifdef BL_PWM_EN
    logic [31:0] div_q, div_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
    logic        pwm_q, pwm_d, pwm_step;

    // Gate with the next bl_en so the PWM output falls on the same edge as bl_en.
    always_comb begin
        pwm_step  = (div_q == PWM_DIV - 1);
        div_d     = pwm_step ? '0 : div_q + 1;
        pwm_cnt_d = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_d    = (pwm_step && pwm_cnt_q == 8'hFF) ? bl_duty : duty_q;
        pwm_d     = (state_nx == ST_ON) && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign bl_pwm = pwm_q;
`else
    logic unused_pwm;
    assign unused_pwm = ^{bl_duty, PWM_DIV};
    assign bl_pwm     = bl_q;
`endif

endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// Bench for lvds_panel_sequencer: phase/dwell reference model checked every cycle,
// literal timing pins for the directed sequences, then randomized req/frame traffic.
module tb_lvds_panel_sequencer;

    localparam int unsigned KHZ = 10;
    localparam int unsigned TMS = 2;
    localparam int          D   = 20;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       panel_on_req = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] bl_duty = 8'd0;
    logic       panel_vdd_en, lvds_en, bl_en, bl_pwm, panel_ready;
    logic [2:0] state;

    int checks = 0;
    int passed = 0;
    int m_ph   = 0;
    int m_rem  = 0;
    bit chk_en = 1'b0;

    lvds_panel_sequencer #(
        .CLK_KHZ(KHZ), .T_VDD_DATA(TMS), .T_DATA_BL(TMS), .T_BL_DATA(TMS),
        .T_DATA_VDD(TMS), .T_OFF_MIN(TMS), .PWM_DIV(1)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .panel_on_req(panel_on_req),
        .frame_start(frame_start), .bl_duty(bl_duty), .panel_vdd_en(panel_vdd_en),
        .lvds_en(lvds_en), .bl_en(bl_en), .bl_pwm(bl_pwm),
        .panel_ready(panel_ready), .state(state)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: phase number plus cycles left in that phase. Every timed phase lasts D cycles.
    always @(posedge clk_in or negedge rst_n) begin
        int nx;
        if (!rst_n) begin
            m_ph  = 0;
            m_rem = 0;
        end else begin
            nx = m_ph;
            case (m_ph)
                0: if (panel_on_req) nx = 1;
                1: if (!panel_on_req) nx = 6; else begin m_rem--; if (m_rem == 0) nx = 2; end
                2: if (!panel_on_req) nx = 6; else if (frame_start) nx = 3;
                3: if (!panel_on_req) nx = 6; else begin m_rem--; if (m_rem == 0) nx = 4; end
                4: if (!panel_on_req) nx = 5;
                default: begin m_rem--; if (m_rem == 0) nx = (m_ph == 7) ? 0 : m_ph + 1; end
            endcase
            if (nx != m_ph) begin
                m_ph  = nx;
                m_rem = D;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en && rst_n) begin
            chk("state", int'(state), m_ph);
            chk("vdd", int'(panel_vdd_en), int'(m_ph >= 1 && m_ph <= 6));
            chk("lvds", int'(lvds_en), int'(m_ph >= 3 && m_ph <= 5));
            chk("bl_en", int'(bl_en), int'(m_ph == 4));
            chk("ready", int'(panel_ready), int'(m_ph == 4));
`ifdef BL_PWM_EN
            if (m_ph != 4) chk("pwm_off", int'(bl_pwm), 0);
`else
            chk("bl_pwm", int'(bl_pwm), int'(m_ph == 4));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic reach_on(input int budget);
        int n;
        n = 0;
        panel_on_req = 1'b1;
        while (m_ph != 4 && n < budget) begin
            frame_start = (m_ph == 2);
            step(1);
            n++;
        end
        frame_start = 1'b0;
        chk("reach_on_timeout", int'(n < budget), 1);
    endtask

    task automatic reach_off(input int budget);
        int n;
        n = 0;
        panel_on_req = 1'b0;
        while (m_ph != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk("reach_off_timeout", int'(n < budget), 1);
    endtask

    initial begin
        #3;
        chk("rst_state", int'(state), 0);
        chk("rst_vdd", int'(panel_vdd_en), 0);
        chk("rst_lvds", int'(lvds_en), 0);
        chk("rst_bl", int'(bl_en), 0);
        chk("rst_pwm", int'(bl_pwm), 0);
        chk("rst_ready", int'(panel_ready), 0);
        repeat (2) @(negedge clk_in);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(2);

        // power-up
        panel_on_req = 1'b1;
        step(1);  chk("t1_vdd_at_1", int'(panel_vdd_en), 1);
        step(19); chk("t1_vdd_on_at_20", int'(state), 1);
        step(1);  chk("t1_wait_frame_at_21", int'(state), 2);
        step(9);  frame_start = 1'b1;
        step(1);  frame_start = 1'b0;
        chk("t1_lvds_at_31", int'(lvds_en), 1);
        step(19); chk("t1_bl_off_at_50", int'(bl_en), 0);
        step(1);  chk("t1_bl_at_51", int'(bl_en), 1);
        chk("t1_ready_at_51", int'(panel_ready), 1);
        step(5);

        // power-down from ON
        panel_on_req = 1'b0;
        step(1);  chk("t2_bl_off_at_1", int'(bl_en), 0);
        step(19); chk("t2_lvds_at_20", int'(lvds_en), 1);
        step(1);  chk("t2_lvds_off_at_21", int'(lvds_en), 0);
        step(19); chk("t2_vdd_at_40", int'(panel_vdd_en), 1);
        step(1);  chk("t2_vdd_off_at_41", int'(panel_vdd_en), 0);
        step(19); chk("t2_hold_at_60", int'(state), 7);
        step(1);  chk("t2_off_at_61", int'(state), 0);

        // abort while waiting for a frame
        panel_on_req = 1'b1;
        step(21); chk("t3_wait_frame", int'(state), 2);
        step(7);  panel_on_req = 1'b0;
        step(1);  chk("t3_data_off", int'(state), 6);
        chk("t3_lvds_low", int'(lvds_en), 0);
        step(19); chk("t3_vdd_at_20", int'(panel_vdd_en), 1);
        step(1);  chk("t3_vdd_off_at_21", int'(panel_vdd_en), 0);
        step(20); chk("t3_off", int'(state), 0);

        // req bouncing during BL_OFF does not stop the shutdown
        panel_on_req = 1'b1;
        step(21); frame_start = 1'b1;
        step(1);  frame_start = 1'b0;
        step(20); chk("t4_on", int'(state), 4);
        panel_on_req = 1'b0;
        step(1);  chk("t4_bl_off", int'(state), 5);
        step(4);  panel_on_req = 1'b1;
        step(3);  panel_on_req = 1'b0;
        step(3);  panel_on_req = 1'b1;
        step(10); chk("t4_data_off_at_20", int'(state), 6);
        step(20); chk("t4_hold_at_40", int'(state), 7);
        step(19); chk("t4_hold_at_59", int'(state), 7);
        step(1);  chk("t4_off_at_60", int'(state), 0);
        step(1);  chk("t4_vdd_on_at_61", int'(state), 1);

        // asynchronous reset while ON
        reach_on(200);
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_state", int'(state), 0);
        chk("t5_vdd", int'(panel_vdd_en), 0);
        chk("t5_lvds", int'(lvds_en), 0);
        chk("t5_bl", int'(bl_en), 0);
        chk("t5_ready", int'(panel_ready), 0);
        panel_on_req = 1'b0;
        @(negedge clk_in);
        #2 rst_n = 1'b1;
        step(2);

        // randomized req/frame traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 69) == 0) panel_on_req = ~panel_on_req;
            frame_start = ($urandom_range(0, 24) == 0);
            bl_duty     = 8'($urandom);
            step(1);
        end
        frame_start = 1'b0;
        reach_off(200);

`ifdef BL_PWM_EN
        begin
            int hi;
            bl_duty = 8'd64;
            reach_on(300);
            step(600);
            hi = 0;
            repeat (256) begin step(1); hi += int'(bl_pwm); end
            chk("t6_duty64", hi, 64);
            bl_duty = 8'd0;
            step(600);
            hi = 0;
            repeat (256) begin step(1); hi += int'(bl_pwm); end
            chk("t6_duty0", hi, 0);
            reach_off(200);
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
